// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state codes seen by both the controller and the data path,
// plus the controller's SDA drive decode.
package i2c_pkg;

  localparam int I2C_STATE_W = 4;

  typedef enum logic [I2C_STATE_W-1:0] {
    ST_IDLE       = 4'd0,
    ST_START      = 4'd1,
    ST_ADDRESS    = 4'd2,
    ST_READ_ACK   = 4'd3,
    ST_WRITE      = 4'd4,
    ST_READ       = 4'd5,
    ST_READ_ACK_1 = 4'd6,
    ST_WRITE_ACK  = 4'd7,
    ST_STOP       = 4'd8
  } i2c_state_e;

  // {sda_sel, sda_ctrl} to present while in a given state.
  function automatic logic [1:0] sda_drive(input i2c_state_e st);
    case (st)
      ST_START, ST_STOP:   return 2'b00;
      ST_ADDRESS, ST_WRITE: return 2'b11;
      default:             return 2'b01;
    endcase
  endfunction

endpackage

// File: rtl/i2c_scl_gen.sv
// SCL generator: half-period divider that toggles SCL on wrap and flags the falling
// (scl_n) and rising (scl_p) edges one cycle ahead. Idles with SCL high and divider at 0.
module i2c_scl_gen #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic scl,
  output logic scl_n,
  output logic scl_p
);

  localparam int DIV_W = $clog2(HALF_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_scl;
  logic             w_wrap;

  assign w_wrap = run && (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      r_div <= '0;
      r_scl <= 1'b1;
    end else if (w_wrap) begin
      r_div <= '0;
      r_scl <= ~r_scl;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign scl   = r_scl;
  assign scl_n = w_wrap & r_scl;
  assign scl_p = w_wrap & ~r_scl;

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master control FSM: sequences START, address, ACK, one data byte and STOP on the
// SCL falling-edge tick, samples ACK on the rising tick, and owns SDA outside data bits.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rw,
  input  logic                   counter,
  input  logic                   sda_in,
  output logic [I2C_STATE_W-1:0] state,
  output logic                   scl_n,
  output logic                   scl,
  output logic                   sda_ctrl,
  output logic                   sda_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err
);

  localparam int HOLD_W = $clog2(HALF_PERIOD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HALF_PERIOD - 1);

  i2c_state_e       r_state;
  logic             r_rw;
  logic             r_ack;
  logic             r_busy;
  logic             r_done;
  logic             r_ack_err;
  logic             r_sda_ctrl;
  logic             r_sda_sel;
  logic [HOLD_W-1:0] r_hold_cnt;

  logic w_scl;
  logic w_scl_n;
  logic w_scl_p;
  logic w_run;
  logic w_stop_hi;
  logic w_stop_end;

  // Once SCL is high in STOP the generator is parked so SCL cannot fall again;
  // the final half period is timed locally instead.
  assign w_stop_hi  = (r_state == ST_STOP) && w_scl;
  assign w_stop_end = w_stop_hi && (r_hold_cnt == HOLD_LAST);
  assign w_run      = r_busy && !w_stop_hi;

  i2c_scl_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_scl_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (w_run),
    .scl  (w_scl),
    .scl_n(w_scl_n),
    .scl_p(w_scl_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rw       <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ack_err  <= 1'b0;
      r_sda_ctrl <= 1'b1;
      r_sda_sel  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_done     <= 1'b0;
      r_hold_cnt <= w_stop_hi ? r_hold_cnt + 1'b1 : '0;
      if (w_scl_p && (r_state == ST_READ_ACK || r_state == ST_READ_ACK_1))
        r_ack <= sda_in;
      case (r_state)
        ST_IDLE: if (start) begin
          r_state   <= ST_START;
          r_rw      <= rw;
          r_ack_err <= 1'b0;
          r_busy    <= 1'b1;
          {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_START);
        end
        ST_START: if (w_scl_n) begin
          r_state <= ST_ADDRESS;
          {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_ADDRESS);
        end
        ST_ADDRESS: if (w_scl_n && counter) begin
          r_state <= ST_READ_ACK;
          {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_READ_ACK);
        end
        ST_READ_ACK: if (w_scl_n) begin
          if (r_ack) begin
            r_state   <= ST_STOP;
            r_ack_err <= 1'b1;
            {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_STOP);
          end else if (r_rw) begin
            r_state <= ST_READ;
            {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_READ);
          end else begin
            r_state <= ST_WRITE;
            {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_WRITE);
          end
        end
        ST_WRITE: if (w_scl_n && counter) begin
          r_state <= ST_READ_ACK_1;
          {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_READ_ACK_1);
        end
        ST_READ_ACK_1: if (w_scl_n) begin
          r_state <= ST_STOP;
          if (r_ack) r_ack_err <= 1'b1;
          {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_STOP);
        end
        ST_READ: if (w_scl_n && counter) begin
          r_state <= ST_WRITE_ACK;
          {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_WRITE_ACK);
        end
        ST_WRITE_ACK: if (w_scl_n) begin
          r_state <= ST_STOP;
          {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_STOP);
        end
        ST_STOP: if (w_stop_end) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_IDLE);
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          {r_sda_sel, r_sda_ctrl} <= sda_drive(ST_IDLE);
        end
      endcase
    end
  end

  assign state    = r_state;
  assign scl      = w_scl;
  assign scl_n    = w_scl_n;
  assign sda_ctrl = r_sda_ctrl;
  assign sda_sel  = r_sda_sel;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ack_err  = r_ack_err;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Self-checking bench for i2c_master_ctrl: a HALF_PERIOD=4 instance for single transactions
// and a HALF_PERIOD=2 instance for back-to-back operation, checked against phase-length rules.
module tb_i2c_master_ctrl;

  localparam int HP4 = 4;
  localparam int HP2 = 2;
  localparam logic [3:0] S_IDLE  = 4'd0, S_START = 4'd1, S_ADDR = 4'd2, S_RACK = 4'd3,
                         S_WR    = 4'd4, S_RD    = 4'd5, S_RACK1 = 4'd6, S_WACK = 4'd7,
                         S_STOP  = 4'd8;

  logic       clk, rst;
  logic       start4, rw4, counter4, sda_in4;
  logic [3:0] st4;
  logic       scl_n4, scl4, sda_ctrl4, sda_sel4, busy4, done4, ack_err4;
  logic       start2, rw2, counter2, sda_in2;
  logic [3:0] st2;
  logic       scl_n2, scl2, sda_ctrl2, sda_sel2, busy2, done2, ack_err2;

  logic       addr_nack, data_nack, noise4, noise_sda4;
  logic [3:0] bitcnt4, bitcnt2;
  int         tests, fails;

  i2c_master_ctrl #(.HALF_PERIOD(HP4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .rw(rw4), .counter(counter4), .sda_in(sda_in4),
    .state(st4), .scl_n(scl_n4), .scl(scl4), .sda_ctrl(sda_ctrl4), .sda_sel(sda_sel4),
    .busy(busy4), .done(done4), .ack_err(ack_err4));

  i2c_master_ctrl #(.HALF_PERIOD(HP2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .rw(rw2), .counter(counter2), .sda_in(sda_in2),
    .state(st2), .scl_n(scl_n2), .scl(scl2), .sda_ctrl(sda_ctrl2), .sda_sel(sda_sel2),
    .busy(busy2), .done(done2), .ack_err(ack_err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic in_data(input logic [3:0] s);
    return (s == S_ADDR) || (s == S_WR) || (s == S_RD);
  endfunction

  // Data path model: flags the 8th SCL bit of each byte; noise elsewhere must be ignored.
  always @(posedge clk) begin
    if (rst || !in_data(st4)) bitcnt4 <= 4'd0;
    else if (scl_n4) bitcnt4 <= bitcnt4 + 4'd1;
    if (rst || !in_data(st2)) bitcnt2 <= 4'd0;
    else if (scl_n2) bitcnt2 <= bitcnt2 + 4'd1;
  end
  assign counter4 = in_data(st4) ? (bitcnt4 == 4'd7) : noise4;
  assign counter2 = in_data(st2) && (bitcnt2 == 4'd7);
  assign sda_in4  = (st4 == S_RACK) ? addr_nack : (st4 == S_RACK1) ? data_nack : noise_sda4;
  assign sda_in2  = 1'b0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 400000", $time);
    $fatal(1, "watchdog");
  end

  task automatic run_txn(input string name, input logic t_rw, input logic a_nack,
                         input logic d_nack, input logic poke);
    string exp_seq, obs;
    int    exp_len, last, s_cyc, d_cyc, n_done;
    logic  exp_err, wack_bad, busy_bad, saw_wack, poked, entry_ok;
    logic [3:0] entry_st;
    exp_seq = "1,2,3";
    if (a_nack)    exp_seq = {exp_seq, ",8,0"};
    else if (t_rw) exp_seq = {exp_seq, ",5,7,8,0"};
    else           exp_seq = {exp_seq, ",4,6,8,0"};
    // START half, address 16 halves, ACK 2, [data 16 + ACK 2], STOP 2
    exp_len = HP4 * (1 + 16 + 2 + (a_nack ? 0 : 18) + 2);
    exp_err = a_nack | (~t_rw & d_nack);
    obs = ""; last = -1; s_cyc = -1; d_cyc = -1; n_done = 0;
    wack_bad = 0; busy_bad = 0; saw_wack = 0; poked = 0; entry_ok = 0; entry_st = 4'd0;
    @(negedge clk);
    start4 = 1'b1; rw4 = t_rw; addr_nack = a_nack; data_nack = d_nack;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        entry_st = st4;
        entry_ok = (st4 == S_START) && busy4 && !ack_err4 && scl4 && !sda_ctrl4 && !sda_sel4;
      end
      if (int'(st4) != last) begin
        obs  = (last < 0) ? $sformatf("%0d", st4) : {obs, $sformatf(",%0d", st4)};
        last = int'(st4);
      end
      if (st4 == S_START && s_cyc < 0) s_cyc = cyc;
      if (done4) begin
        n_done++;
        if (d_cyc < 0) d_cyc = cyc;
      end
      if (st4 == S_WACK) begin
        saw_wack = 1;
        if (sda_ctrl4 !== 1'b1 || sda_sel4 !== 1'b0) wack_bad = 1;
      end
      if (busy4 !== (st4 != S_IDLE)) busy_bad = 1;
      start4 = 1'b0;
      if (poke && !poked && st4 == S_WR) begin
        start4 = 1'b1;
        poked  = 1;
      end
      rw4        = 1'($urandom);
      noise4     = 1'($urandom);
      noise_sda4 = 1'($urandom);
      if (d_cyc >= 0 && cyc >= d_cyc + 8 * HP4) break;
    end
    start4 = 1'b0;
    tests++;
    if (!entry_ok) begin
      fails++;
      $display("FAIL %s start_entry: got state=%0d busy=%0b ack_err=%0b scl=%0b sda_ctrl=%0b, required state=1 busy=1 ack_err=0 scl=1 sda_ctrl=0",
               name, entry_st, busy4, ack_err4, scl4, sda_ctrl4);
    end
    tests++;
    if (d_cyc < 0) begin
      fails++;
      $display("FAIL %s done_timeout: got no done in 1500 cycles, required one done", name);
    end
    tests++;
    if (obs != exp_seq) begin
      fails++;
      $display("FAIL %s state_seq: got %s required %s", name, obs, exp_seq);
    end
    tests++;
    if (n_done != 1) begin
      fails++;
      $display("FAIL %s done_count: got %0d required 1", name, n_done);
    end
    tests++;
    if (d_cyc - s_cyc != exp_len) begin
      fails++;
      $display("FAIL %s done_latency: got %0d required %0d", name, d_cyc - s_cyc, exp_len);
    end
    tests++;
    if (ack_err4 !== exp_err) begin
      fails++;
      $display("FAIL %s ack_err: got %0b required %0b", name, ack_err4, exp_err);
    end
    if (saw_wack) begin
      tests++;
      if (wack_bad) begin
        fails++;
        $display("FAIL %s write_ack_sda: got a cycle not sda_ctrl=1/sda_sel=0, required sda_ctrl=1 sda_sel=0", name);
      end
    end
    tests++;
    if (busy_bad) begin
      fails++;
      $display("FAIL %s busy: got busy inconsistent with state, required busy=(state!=0)", name);
    end
    $display("[TB] txn %s rw=%0b addr_nack=%0b data_nack=%0b seq=%s done_after=%0d ack_err=%0b",
             name, t_rw, a_nack, d_nack, obs, d_cyc - s_cyc, ack_err4);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (st4 !== S_IDLE || st2 !== S_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d/%0d required 0/0", st4, st2);
    end
    tests++;
    if ({scl4, scl_n4, sda_ctrl4, sda_sel4} !== 4'b1010) begin
      fails++;
      $display("FAIL reset_lines: got scl,scl_n,sda_ctrl,sda_sel=%b required 1010",
               {scl4, scl_n4, sda_ctrl4, sda_sel4});
    end
    tests++;
    if ({busy4, done4, ack_err4} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got busy,done,ack_err=%b required 000", {busy4, done4, ack_err4});
    end
    tests++;
    if ({scl2, scl_n2, sda_ctrl2, sda_sel2, busy2, done2, ack_err2} !== 7'b1010000) begin
      fails++;
      $display("FAIL reset_hp2: got %b required 1010000",
               {scl2, scl_n2, sda_ctrl2, sda_sel2, busy2, done2, ack_err2});
    end
    rst = 1'b0;
    begin
      logic idle_bad;
      idle_bad = 0;
      repeat (6 * HP4) begin
        @(negedge clk);
        if (st4 !== S_IDLE || scl4 !== 1'b1 || scl_n4 !== 1'b0 || busy4 !== 1'b0) idle_bad = 1;
      end
      tests++;
      if (idle_bad) begin
        fails++;
        $display("FAIL idle_hold: got activity with start low, required state=0 scl=1 scl_n=0 busy=0");
      end
    end
    $display("[TB] txn reset checked");
  endtask

  task automatic test_write;       run_txn("write_ack", 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic test_read;        run_txn("read_ack",  1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic test_data_nack;   run_txn("write_data_nack", 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic test_start_in_write; run_txn("start_in_write", 1'b0, 1'b0, 1'b0, 1'b1); endtask

  task automatic test_addr_nack;
    run_txn("addr_nack", 1'($urandom), 1'b1, 1'($urandom), 1'b0);
    // ack_err must survive in IDLE and be cleared by the next accept (checked at entry)
    run_txn("after_nack", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++)
      run_txn($sformatf("rand%0d", i), 1'($urandom), ($urandom_range(0, 3) == 0),
              1'($urandom), 1'b0);
  endtask

  task automatic test_rst_mid_address;
    logic post_bad;
    int   k;
    post_bad = 0;
    @(negedge clk);
    start4 = 1'b1; rw4 = 1'($urandom); addr_nack = 1'b0; data_nack = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 100 && st4 != S_ADDR; i++) @(negedge clk);
    tests++;
    if (st4 !== S_ADDR) begin
      fails++;
      $display("FAIL rst_reach_addr: got state %0d required 2", st4);
    end
    k = $urandom_range(0, 40);
    repeat (k) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (st4 !== S_IDLE || scl4 !== 1'b1 || sda_ctrl4 !== 1'b1 || busy4 !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_addr: got state=%0d scl=%0b sda_ctrl=%0b busy=%0b required 0 1 1 0",
               st4, scl4, sda_ctrl4, busy4);
    end
    tests++;
    if (sda_sel4 !== 1'b0 || scl_n4 !== 1'b0 || done4 !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_addr_aux: got sda_sel=%0b scl_n=%0b done=%0b required 0 0 0",
               sda_sel4, scl_n4, done4);
    end
    rst = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (done4 !== 1'b0 || st4 !== S_IDLE) post_bad = 1;
    end
    tests++;
    if (post_bad) begin
      fails++;
      $display("FAIL rst_no_done: got done or activity after reset, required quiet IDLE");
    end
    $display("[TB] txn rst_mid_address after %0d ADDRESS cycles", k);
  endtask

  task automatic test_back_to_back;
    int   n_scln, n_done, s1, d1, d2;
    logic prev, width_bad, restart_ok;
    n_scln = 0; n_done = 0; s1 = -1; d1 = -1; d2 = -1;
    prev = 0; width_bad = 0; restart_ok = 0;
    @(negedge clk);
    start2 = 1'b1; rw2 = 1'($urandom);
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (scl_n2 && prev) width_bad = 1;
      prev = scl_n2;
      if (scl_n2) n_scln++;
      if (st2 == S_START && s1 < 0) s1 = cyc;
      if (done2) begin
        n_done++;
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
      end
      if (d1 >= 0 && cyc == d1 + 1) begin
        restart_ok = (st2 == S_START);
        start2 = 1'b0;
      end
      rw2 = 1'($urandom);
      if (d2 >= 0 && cyc >= d2 + 20) break;
    end
    start2 = 1'b0;
    tests++;
    if (s1 != 0 || d1 - s1 != 39 * HP2) begin
      fails++;
      $display("FAIL b2b_first: got entry=%0d latency=%0d required 0 and %0d", s1, d1 - s1, 39 * HP2);
    end
    tests++;
    if (!restart_ok) begin
      fails++;
      $display("FAIL b2b_restart: got state!=START the cycle after done, required START");
    end
    tests++;
    if (d2 < 0 || d2 - (d1 + 1) != 39 * HP2) begin
      fails++;
      $display("FAIL b2b_second: got latency=%0d required %0d", d2 - (d1 + 1), 39 * HP2);
    end
    tests++;
    if (width_bad) begin
      fails++;
      $display("FAIL b2b_scl_n_width: got scl_n high 2+ cycles, required 1-cycle pulses");
    end
    tests++;
    if (n_scln != 2 * 19 || n_done != 2) begin
      fails++;
      $display("FAIL b2b_counts: got scl_n=%0d done=%0d required %0d and 2", n_scln, n_done, 2 * 19);
    end
    $display("[TB] txn back_to_back hp=2 done_at=%0d,%0d scl_n=%0d", d1, d2, n_scln);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    start4 = 1'b0; rw4 = 1'b0; addr_nack = 1'b0; data_nack = 1'b0;
    noise4 = 1'b0; noise_sda4 = 1'b1;
    start2 = 1'b0; rw2 = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_addr_nack;
    test_data_nack;
    test_random;
    test_rst_mid_address;
    test_start_in_write;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
